// File: rtl/teacher_pkg.sv
// -----------------------------------------------------------------------------
// teacher_pkg
//
// Shared types and constants for the teacher block, which closes the training
// loop around a perceptron stage.
//
// Contents:
//   teacher_state_e  FSM state encoding (idle / error / propagate)
//   DataW            width of the result and target values
//   ErrW             width of the signed error returned to the stage
//   calc_error       target - result, sign-extended to ErrW and scaled
// -----------------------------------------------------------------------------
package teacher_pkg;

    localparam int unsigned DataW = 8;
    localparam int unsigned ErrW  = 16;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StError     = 2'd1,
        StPropagate = 2'd2
    } teacher_state_e;

    // The 9-bit difference spans -255..255. After sign extension to 16 bits a
    // left shift of up to 7 stays in range, so no saturation is needed.
    function automatic logic signed [ErrW-1:0] calc_error(
        input logic [DataW-1:0] target,
        input logic [DataW-1:0] result,
        input int unsigned      shift
    );
        logic signed [DataW:0]  diff;
        logic signed [ErrW-1:0] ext;
        diff = $signed({1'b0, target}) - $signed({1'b0, result});
        ext  = {{(ErrW-DataW-1){diff[DataW]}}, diff};
        return ext <<< shift;
    endfunction

endpackage

// File: rtl/saturating_counter.sv
// -----------------------------------------------------------------------------
// saturating_counter
//
// Up-counter that sticks at all ones. A synchronous clear takes priority over
// an increment in the same cycle.
//
// Ports:
//   clock      system clock
//   reset      asynchronous active-low reset, zeroes the count
//   clear      synchronous clear
//   increment  add one this cycle (ignored once saturated)
//   count      current count
// -----------------------------------------------------------------------------
module saturating_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         increment,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] One = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         saturated;

    assign saturated = &count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (increment && !saturated) begin
            count_d = count_q + One;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/teacher.sv
// -----------------------------------------------------------------------------
// teacher
//
// Joins the stage's forward result with a target value, and when training
// returns the scaled signed error (target - result) on the stage's error
// channel, then sinks the stage's backward propagate beat so its handshake
// completes. Sample and mistake counters track convergence.
//
// Ports:
//   clock, reset                      clock and asynchronous active-low reset
//   train                             training enable, sampled at capture
//   clear                             synchronous counter clear
//   result_valid/ready/data           forward result from stage (join input)
//   target_valid/ready/data           expected value (join input)
//   error_valid/ready/data            signed error to stage
//   propagate_valid/ready/data        backward propagate from stage, discarded
//   samples, mistakes                 saturating counters
// -----------------------------------------------------------------------------
module teacher
    import teacher_pkg::*;
#(
    parameter int unsigned N       = 2,
    parameter int unsigned SHIFT   = 0,
    parameter int unsigned COUNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  train,
    input  logic                  clear,

    input  logic                  result_valid,
    input  logic [DataW-1:0]      result_data,
    output logic                  result_ready,

    input  logic                  target_valid,
    input  logic [DataW-1:0]      target_data,
    output logic                  target_ready,

    output logic                  error_valid,
    output logic [ErrW-1:0]       error_data,
    input  logic                  error_ready,

    input  logic                  propagate_valid,
    input  logic [N-1:0][ErrW-1:0] propagate_data,
    output logic                  propagate_ready,

    output logic [COUNT_W-1:0]    samples,
    output logic [COUNT_W-1:0]    mistakes
);

    teacher_state_e  state_q;
    logic            error_valid_q;
    logic [ErrW-1:0] error_data_q;

    logic join_fire;
    logic mismatch;

    // Both join inputs are accepted together and only in idle. Gating with
    // reset keeps the readies low while reset is held.
    assign join_fire = reset && (state_q == StIdle) && result_valid && target_valid;
    assign mismatch  = (target_data != result_data);

    assign result_ready    = join_fire;
    assign target_ready    = join_fire;
    assign propagate_ready = (state_q == StPropagate);
    assign error_valid     = error_valid_q;
    assign error_data      = error_data_q;

    // Propagated error is only consumed to complete the handshake.
    logic unused_propagate;
    assign unused_propagate = ^propagate_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            error_valid_q <= 1'b0;
            error_data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (join_fire) begin
                        error_data_q <= calc_error(target_data, result_data, SHIFT);
                        if (train) begin
                            state_q       <= StError;
                            error_valid_q <= 1'b1;
                        end
                    end
                end
                StError: begin
                    if (error_ready) begin
                        state_q       <= StPropagate;
                        error_valid_q <= 1'b0;
                    end
                end
                StPropagate: begin
                    if (propagate_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    error_valid_q <= 1'b0;
                end
            endcase
        end
    end

    saturating_counter #(
        .W (COUNT_W)
    ) u_samples (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .increment (join_fire),
        .count     (samples)
    );

    saturating_counter #(
        .W (COUNT_W)
    ) u_mistakes (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .increment (join_fire && mismatch),
        .count     (mistakes)
    );

endmodule

// File: tb/tb_teacher.sv
module tb_teacher;

    logic        clock;
    logic        reset;
    logic        train;
    logic        clear;
    logic        result_valid;
    logic [7:0]  result_data;
    logic        target_valid;
    logic [7:0]  target_data;
    logic        error_ready;
    logic        propagate_valid;
    logic [1:0][15:0] propagate_data;

    // dut0: SHIFT=0, COUNT_W=16
    logic        rr0, tr0, ev0, pr0;
    logic [15:0] ed0, samples0, mistakes0;
    // dut2: SHIFT=2, COUNT_W=2
    logic        rr2, tr2, ev2, pr2;
    logic [15:0] ed2;
    logic [1:0]  samples2, mistakes2;

    int checks = 0;
    int errors = 0;

    teacher #(.N(2), .SHIFT(0), .COUNT_W(16)) dut0 (
        .clock(clock), .reset(reset), .train(train), .clear(clear),
        .result_valid(result_valid), .result_data(result_data), .result_ready(rr0),
        .target_valid(target_valid), .target_data(target_data), .target_ready(tr0),
        .error_valid(ev0), .error_data(ed0), .error_ready(error_ready),
        .propagate_valid(propagate_valid), .propagate_data(propagate_data),
        .propagate_ready(pr0), .samples(samples0), .mistakes(mistakes0)
    );

    teacher #(.N(2), .SHIFT(2), .COUNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .train(train), .clear(clear),
        .result_valid(result_valid), .result_data(result_data), .result_ready(rr2),
        .target_valid(target_valid), .target_data(target_data), .target_ready(tr2),
        .error_valid(ev2), .error_data(ed2), .error_ready(error_ready),
        .propagate_valid(propagate_valid), .propagate_data(propagate_data),
        .propagate_ready(pr2), .samples(samples2), .mistakes(mistakes2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_pair(input logic [7:0] r, input logic [7:0] t, input logic tr);
        result_data  = r;
        target_data  = t;
        train        = tr;
        result_valid = 1'b1;
        target_valid = 1'b1;
    endtask

    task automatic idle_inputs();
        result_valid    = 1'b0;
        target_valid    = 1'b0;
        error_ready     = 1'b0;
        propagate_valid = 1'b0;
        clear           = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if ({rr0, tr0, ev0, pr0} !== 4'b0000) begin
            errors++; $display("FAIL reset_handshake: got %b want 0000", {rr0, tr0, ev0, pr0});
        end
        checks++; if (ed0 !== 16'h0000) begin
            errors++; $display("FAIL reset_error_data: got %h want 0000", ed0);
        end
        checks++; if (samples0 !== 16'd0 || mistakes0 !== 16'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", samples0, mistakes0);
        end
        // Readies must stay low under reset even with both valids present.
        drive_pair(8'd1, 8'd2, 1'b0);
        #1;
        checks++; if (rr0 !== 1'b0 || tr0 !== 1'b0) begin
            errors++; $display("FAIL reset_ready_gated: got %b%b want 00", rr0, tr0);
        end
        idle_inputs();
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_train_basic();
        drive_pair(8'd0, 8'd255, 1'b1);
        #1;
        checks++; if (rr0 !== 1'b1 || tr0 !== 1'b1) begin
            errors++; $display("FAIL basic_join_ready: got %b%b want 11", rr0, tr0);
        end
        tick();
        idle_inputs();
        train = 1'b0; // must not affect the transaction in flight
        checks++; if (ev0 !== 1'b1 || ed0 !== 16'h00FF) begin
            errors++; $display("FAIL basic_error: got v=%b d=%h want v=1 d=00ff", ev0, ed0);
        end
        checks++; if (ed2 !== 16'h03FC) begin
            errors++; $display("FAIL basic_error_shift2: got %h want 03fc", ed2);
        end
        checks++; if (rr0 !== 1'b0) begin
            errors++; $display("FAIL basic_busy_ready: got %b want 0", rr0);
        end
        error_ready = 1'b1;
        tick();
        error_ready = 1'b0;
        checks++; if (ev0 !== 1'b0 || pr0 !== 1'b1) begin
            errors++; $display("FAIL basic_propagate: got ev=%b pr=%b want ev=0 pr=1", ev0, pr0);
        end
        propagate_valid = 1'b1;
        propagate_data  = {16'hDEAD, 16'hBEEF};
        tick();
        propagate_valid = 1'b0;
        checks++; if (pr0 !== 1'b0 || ev0 !== 1'b0) begin
            errors++; $display("FAIL basic_back_idle: got pr=%b ev=%b want 0 0", pr0, ev0);
        end
        checks++; if (samples0 !== 16'd1 || mistakes0 !== 16'd1) begin
            errors++; $display("FAIL basic_counters: got %0d/%0d want 1/1", samples0, mistakes0);
        end
    endtask

    task automatic test_hold();
        drive_pair(8'd255, 8'd0, 1'b1);
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            checks++; if (ev2 !== 1'b1 || ed2 !== 16'hFC04) begin
                errors++; $display("FAIL hold_cycle%0d: got v=%b d=%h want v=1 d=fc04", i, ev2, ed2);
            end
            checks++; if (ed0 !== 16'hFF01) begin
                errors++; $display("FAIL hold_shift0_cycle%0d: got %h want ff01", i, ed0);
            end
            tick();
        end
        error_ready = 1'b1;
        tick();
        error_ready = 1'b0;
        propagate_valid = 1'b1;
        tick();
        propagate_valid = 1'b0;
        checks++; if (pr2 !== 1'b0 || ev2 !== 1'b0) begin
            errors++; $display("FAIL hold_done: got pr=%b ev=%b want 0 0", pr2, ev2);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rs [4] = '{8'd0, 8'd0, 8'd255, 8'd255};
        logic [7:0] ts [4] = '{8'd0, 8'd255, 8'd255, 8'd0};
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            drive_pair(rs[i], ts[i], 1'b0);
            #1;
            checks++; if (rr0 !== 1'b1 || tr0 !== 1'b1) begin
                errors++; $display("FAIL b2b_ready%0d: got %b%b want 11", i, rr0, tr0);
            end
            tick();
            checks++; if (ev0 !== 1'b0) begin
                errors++; $display("FAIL b2b_no_error%0d: got %b want 0", i, ev0);
            end
        end
        idle_inputs();
        checks++; if (samples0 !== 16'd4 || mistakes0 !== 16'd2) begin
            errors++; $display("FAIL b2b_counters: got %0d/%0d want 4/2", samples0, mistakes0);
        end
    endtask

    task automatic test_join();
        target_valid = 1'b1;
        target_data  = 8'd7;
        result_data  = 8'd7;
        train        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rr0 !== 1'b0 || tr0 !== 1'b0) begin
                errors++; $display("FAIL join_wait%0d: got %b%b want 00", i, rr0, tr0);
            end
            tick();
        end
        result_valid = 1'b1;
        #1;
        checks++; if (rr0 !== 1'b1 || tr0 !== 1'b1) begin
            errors++; $display("FAIL join_fire: got %b%b want 11", rr0, tr0);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_saturation();
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            drive_pair(8'(i), 8'(i + 10), 1'b0);
            tick();
        end
        checks++; if (samples2 !== 2'd3 || mistakes2 !== 2'd3) begin
            errors++; $display("FAIL sat_count_w2: got %0d/%0d want 3/3", samples2, mistakes2);
        end
        checks++; if (samples0 !== 16'd5 || mistakes0 !== 16'd5) begin
            errors++; $display("FAIL sat_count_w16: got %0d/%0d want 5/5", samples0, mistakes0);
        end
        drive_pair(8'd1, 8'd2, 1'b0);
        clear = 1'b1;
        tick();
        idle_inputs();
        checks++; if (samples2 !== 2'd0 || mistakes2 !== 2'd0) begin
            errors++; $display("FAIL sat_clear_wins: got %0d/%0d want 0/0", samples2, mistakes2);
        end
        checks++; if (samples0 !== 16'd0 || mistakes0 !== 16'd0) begin
            errors++; $display("FAIL sat_clear_w16: got %0d/%0d want 0/0", samples0, mistakes0);
        end
    endtask

    task automatic test_reset_mid();
        drive_pair(8'd10, 8'd20, 1'b1);
        tick();
        idle_inputs();
        checks++; if (ev0 !== 1'b1 || samples0 !== 16'd1) begin
            errors++; $display("FAIL mid_pre: got ev=%b s=%0d want ev=1 s=1", ev0, samples0);
        end
        reset = 1'b0;
        #1;
        checks++; if (ev0 !== 1'b0 || ed0 !== 16'h0000) begin
            errors++; $display("FAIL mid_async: got ev=%b d=%h want ev=0 d=0000", ev0, ed0);
        end
        @(negedge clock);
        reset = 1'b1;
        propagate_valid = 1'b1;
        #1;
        checks++; if (pr0 !== 1'b0) begin
            errors++; $display("FAIL mid_prop_ready: got %b want 0", pr0);
        end
        tick();
        propagate_valid = 1'b0;
        checks++; if (ev0 !== 1'b0 || pr0 !== 1'b0) begin
            errors++; $display("FAIL mid_after: got ev=%b pr=%b want 0 0", ev0, pr0);
        end
        checks++; if (samples0 !== 16'd0 || mistakes0 !== 16'd0) begin
            errors++; $display("FAIL mid_counters: got %0d/%0d want 0/0", samples0, mistakes0);
        end
        drive_pair(8'd3, 8'd3, 1'b0);
        #1;
        checks++; if (rr0 !== 1'b1) begin
            errors++; $display("FAIL mid_idle_ready: got %b want 1", rr0);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        reset          = 1'b0;
        train          = 1'b0;
        result_data    = '0;
        target_data    = '0;
        propagate_data = '0;
        idle_inputs();
        #12;
        test_reset();
        test_train_basic();
        test_hold();
        test_back_to_back();
        test_join();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
